ram_port_arb: RTL and testbench

Arbiter that shares one single-port synchronous RAM between a write requester and a read requester. Typical use is FIFO buffering where the write and read address streams must reach a single-port RAM macro. Each requester uses a req/gnt handshake. The block drives the RAM command bus directly and returns read data through a fixed-latency pipeline. Arbitration is round-robin with bounded bursts.

---
 rtl/ram_port_arb.sv | 139 +++++++++++++
 tb/tb_ram_port_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arb.sv
// ram_port_arb: shares one single-port synchronous RAM between a write
// requester and a read requester. Round-robin arbitration with bounded
// bursts under conflict, zero-latency grants, and a two-stage read return
// path (RAM read data arrives the cycle after the access and is captured).
//
// Optional feature macro: RAM_PORT_ARB_BURST_EN
//   defined   : up to BURST_LEN consecutive grants to one side under conflict
//   undefined : BURST_LEN is ignored; conflicting grants strictly alternate
module ram_port_arb #(
    parameter int RAM_SIZE   = 1024,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    localparam int AW        = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  wr_req_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_gnt_o,
    input  logic                  rd_req_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic                  rd_gnt_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  ram_clke_o,
    output logic                  ram_we_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  busy_o
);

`ifdef RAM_PORT_ARB_BURST_EN
    localparam int EFF_BURST = (BURST_LEN < 1) ? 1 : BURST_LEN;
`else
    // A burst limit of one turns the round-robin into strict alternation.
    localparam int EFF_BURST = 1;
`endif
    localparam int CW = $clog2(EFF_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(EFF_BURST);

    // Arbitration state: current owner (0 = write, 1 = read) and burst count.
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic          w_owner_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Read return pipeline.
    logic                  r_rd_p1;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic w_wr_gnt;
    logic w_rd_gnt;
    logic w_gnt_any;
    logic w_gnt_owner;

    // Grant selection; grants are forced low while reset is asserted.
    always_comb begin
        w_wr_gnt = 1'b0;
        w_rd_gnt = 1'b0;
        if (!rstn_i) begin
            w_wr_gnt = 1'b0;
            w_rd_gnt = 1'b0;
        end else if (wr_req_i && rd_req_i) begin
            if (r_cnt < BURST_MAX) begin
                w_wr_gnt = ~r_owner;
                w_rd_gnt =  r_owner;
            end else begin
                w_wr_gnt =  r_owner;
                w_rd_gnt = ~r_owner;
            end
        end else begin
            w_wr_gnt = wr_req_i;
            w_rd_gnt = rd_req_i;
        end
    end

    assign w_gnt_any   = w_wr_gnt | w_rd_gnt;
    assign w_gnt_owner = r_owner ? w_rd_gnt : w_wr_gnt;

    // Next owner/burst count: extend the burst, hand over, or idle-clear.
    always_comb begin
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (!w_gnt_any) begin
            w_cnt_nxt = {CW{1'b0}};
        end else if (w_gnt_owner) begin
            if (r_cnt < BURST_MAX) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end else begin
            w_owner_nxt = w_rd_gnt;
            w_cnt_nxt   = CW'(1);
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_owner <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read pipeline: flag the access cycle, then capture RAM data a cycle later.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_p1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rd_p1    <= w_rd_gnt;
            r_rd_valid <= r_rd_p1;
            if (r_rd_p1) begin
                r_rd_data <= ram_rdata_i;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    assign wr_gnt_o    = w_wr_gnt;
    assign rd_gnt_o    = w_rd_gnt;
    assign ram_clke_o  = w_gnt_any;
    assign ram_we_o    = w_wr_gnt;
    assign ram_addr_o  = w_wr_gnt ? wr_addr_i : rd_addr_i;
    assign ram_wdata_o = wr_data_i;
    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign busy_o      = r_rd_p1 | r_rd_valid;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed testbench for ram_port_arb with a behavioural single-port RAM.
module tb_ram_port_arb;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk;
    logic          rstn;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          ram_clke;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    logic          tb_mem_clr;
    logic [DW-1:0] mem [0:1023];

    int n_assert = 0;
    int n_fail   = 0;

    ram_port_arb #(.RAM_SIZE(1024), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_gnt_o    (wr_gnt),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_gnt_o    (rd_gnt),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .ram_clke_o  (ram_clke),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        pat = DW'(a * 17 + 15);
    endfunction

    // Single-port synchronous RAM: read data appears the cycle after access.
    always @(posedge clk) begin
        if (tb_mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            ram_rdata <= 8'h00;
        end else if (ram_clke) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_w;
        logic [DW-1:0] exp_d;

        rstn = 1'b0; tb_mem_clr = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset state, with both requests raised to show grants are blocked.
        repeat (2) @(negedge clk);
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
        chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("rst_clke",   32'(ram_clke), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_valid",  32'(rd_valid), 32'd0);
        chk("rst_data",   32'(rd_data), 32'd0);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0; rstn = 1'b1; tb_mem_clr = 1'b0;

        // Single write of 0xA5 to address 5, then read it back.
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 10'd5; wr_data = 8'hA5;
        #1;
        chk("w5_gnt",   32'(wr_gnt), 32'd1);
        chk("w5_rdgnt", 32'(rd_gnt), 32'd0);
        chk("w5_we",    32'(ram_we), 32'd1);
        chk("w5_addr",  32'(ram_addr), 32'd5);
        chk("w5_wdata", 32'(ram_wdata), 32'hA5);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 10'd5;
        #1;
        chk("r5_gnt",  32'(rd_gnt), 32'd1);
        chk("r5_we",   32'(ram_we), 32'd0);
        chk("r5_clke", 32'(ram_clke), 32'd1);
        chk("r5_addr", 32'(ram_addr), 32'd5);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("r5_p1_valid", 32'(rd_valid), 32'd0);
        chk("r5_p1_busy",  32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("r5_valid", 32'(rd_valid), 32'd1);
        chk("r5_data",  32'(rd_data), 32'hA5);
        @(negedge clk);
        #1;
        chk("r5_valid_drop", 32'(rd_valid), 32'd0);
        chk("r5_data_held",  32'(rd_data), 32'hA5);
        chk("r5_busy_drop",  32'(busy), 32'd0);

        // Back-to-back reads of addresses 0..7.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_req  = (i < 8);
            rd_addr = AW'(i);
            #1;
            if (i < 8) chk("seq_rd_gnt", 32'(rd_gnt), 32'd1);
            if (i >= 2) begin
                exp_d = (i - 2 == 5) ? 8'hA5 : pat(i - 2);
                chk("seq_valid", 32'(rd_valid), 32'd1);
                chk("seq_data",  32'(rd_data), 32'(exp_d));
            end else begin
                chk("seq_valid_lead", 32'(rd_valid), 32'd0);
            end
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("seq_valid_end", 32'(rd_valid), 32'd0);

        // Reset asserted the cycle after a read grant.
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 10'd2;
        #1;
        chk("mid_rd_gnt", 32'(rd_gnt), 32'd1);
        @(negedge clk);
        rstn = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        wr_addr = 10'd900; wr_data = 8'h5A; rd_addr = 10'd3;
        #1;
        chk("mid_busy",   32'(busy), 32'd0);
        chk("mid_valid",  32'(rd_valid), 32'd0);
        chk("mid_data",   32'(rd_data), 32'd0);
        chk("mid_wr_gnt", 32'(wr_gnt), 32'd0);
        chk("mid_rd_gnt0", 32'(rd_gnt), 32'd0);
        chk("mid_clke",   32'(ram_clke), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Both requests held for 12 cycles from reset.
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
`ifdef RAM_PORT_ARB_BURST_EN
            exp_w = (((k / 4) % 2) == 0);
`else
            exp_w = ((k % 2) == 0);
`endif
            chk("conf_wr_gnt", 32'(wr_gnt), 32'(exp_w));
            chk("conf_rd_gnt", 32'(rd_gnt), 32'(!exp_w));
            if (k < 3) chk("post_rst_no_valid", 32'(rd_valid), 32'd0);
        end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (3) @(negedge clk);

        // Top address: write 0x3C to 1023, then read it back.
        wr_req = 1'b1; wr_addr = 10'd1023; wr_data = 8'h3C;
        #1;
        chk("w1023_gnt",  32'(wr_gnt), 32'd1);
        chk("w1023_addr", 32'(ram_addr), 32'd1023);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 10'd1023;
        #1;
        chk("r1023_gnt",  32'(rd_gnt), 32'd1);
        chk("r1023_addr", 32'(ram_addr), 32'd1023);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        #1;
        chk("r1023_valid", 32'(rd_valid), 32'd1);
        chk("r1023_data",  32'(rd_data), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
